// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch : instruction-fetch front end.
//
// Takes the PC, runs a req/ack handshake with a variable-latency instruction
// memory, latches the returned word and hands back inst / inst_pc / npc with
// a one-cycle inst_valid pulse. stall is high for every cycle a fetch is
// outstanding. Misaligned PCs never reach memory; they complete the next
// cycle with fetch_err and a NOP.
//
// Optional feature, enabled by defining the macro IFETCH_TIMEOUT_EN:
//   a wait counter aborts a request that sees no ack for TIMEOUT cycles and
//   completes it with fetch_err and a NOP. Without the macro there is no
//   counter and a request waits for its ack indefinitely.
//
// Memory handshake: imem_req rises on the edge that accepts a fetch and stays
// high, with imem_addr frozen, until the edge on which imem_ack is sampled
// high; that edge transfers imem_rdata. imem_ack is ignored while imem_req is
// low, so a late ack after an abort or reset has no effect.
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          DATA_W   = 32,
   parameter int unsigned          TIMEOUT  = 15,
   parameter logic [DATA_W-1:0]    NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] npc,
   output logic              inst_valid,
   output logic              stall,
   output logic              fetch_err,
   output logic              dbg_state_o
);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t              state_q;
   logic                imem_req_q;
   logic [ADDR_W-1:0]   imem_addr_q;
   logic [DATA_W-1:0]   inst_q;
   logic [ADDR_W-1:0]   inst_pc_q;
   logic [ADDR_W-1:0]   npc_q;
   logic                inst_valid_q;
   logic                fetch_err_q;

   // Next-npc candidates: one for a completed memory fetch, one for a
   // misaligned PC that is answered without touching memory.
   logic [ADDR_W-1:0]   ack_npc_d;
   logic [ADDR_W-1:0]   pc_npc_d;
   logic                pc_aligned_d;

`ifdef IFETCH_TIMEOUT_EN
   logic [7:0]          wait_cnt_q;
   logic                timeout_hit_d;
`endif

   // Address arithmetic is unsigned and wraps modulo 2^ADDR_W.
   always_comb begin
      ack_npc_d    = imem_addr_q + ADDR_W'(4);
      pc_npc_d     = pc + ADDR_W'(4);
      pc_aligned_d = (pc[1:0] == 2'b00);
   end

`ifdef IFETCH_TIMEOUT_EN
   // Abort point: the REQ cycle whose counter value is TIMEOUT-1.
   always_comb begin
      timeout_hit_d = (wait_cnt_q == 8'(TIMEOUT - 1));
   end
`endif

   // Fetch FSM: all outputs registered; pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         imem_req_q   <= 1'b0;
         imem_addr_q  <= '0;
         inst_q       <= NOP_INST;
         inst_pc_q    <= '0;
         npc_q        <= ADDR_W'(4);
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         wait_cnt_q   <= '0;
`endif
      end else begin
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fetch_en) begin
                  if (pc_aligned_d) begin
                     imem_addr_q <= pc;
                     imem_req_q  <= 1'b1;
                     state_q     <= REQ;
`ifdef IFETCH_TIMEOUT_EN
                     wait_cnt_q  <= '0;
`endif
                  end else begin
                     // Misaligned: answer locally with a NOP and an error.
                     inst_q       <= NOP_INST;
                     inst_pc_q    <= pc;
                     npc_q        <= pc_npc_d;
                     inst_valid_q <= 1'b1;
                     fetch_err_q  <= 1'b1;
                  end
               end
            end

            REQ: begin
               // An ack on the same edge as the timeout still completes
               // normally, so ack is tested first.
               if (imem_ack) begin
                  inst_q       <= imem_rdata;
                  inst_pc_q    <= imem_addr_q;
                  npc_q        <= ack_npc_d;
                  inst_valid_q <= 1'b1;
                  imem_req_q   <= 1'b0;
                  state_q      <= IDLE;
               end
`ifdef IFETCH_TIMEOUT_EN
               else if (timeout_hit_d) begin
                  inst_q       <= NOP_INST;
                  inst_pc_q    <= imem_addr_q;
                  npc_q        <= ack_npc_d;
                  inst_valid_q <= 1'b1;
                  fetch_err_q  <= 1'b1;
                  imem_req_q   <= 1'b0;
                  state_q      <= IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
`endif
            end

            default: begin
               state_q    <= IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign npc         = npc_q;
   assign inst_valid  = inst_valid_q;
   assign fetch_err   = fetch_err_q;
   assign stall       = (state_q == REQ);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch : directed bench for inst_fetch.
// The main sequence drives the core and memory sides and pushes the expected
// completion {fetch_err, npc, inst_pc, inst} for every fetch it starts; a
// forked monitor pops and compares on each inst_valid pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SB_W   = 1 + ADDR_W + ADDR_W + DATA_W;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk;
   logic              rst_n;
   logic              fetch_en;
   logic [ADDR_W-1:0] pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic [DATA_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;
   logic [ADDR_W-1:0] npc;
   logic              inst_valid;
   logic              stall;
   logic              fetch_err;
   logic              dbg_state_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [SB_W-1:0] exp_q[$];

   inst_fetch #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .TIMEOUT  (15),
      .NOP_INST (NOP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_en    (fetch_en),
      .pc          (pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .npc         (npc),
      .inst_valid  (inst_valid),
      .stall       (stall),
      .fetch_err   (fetch_err),
      .dbg_state_o (dbg_state_o)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] i, input logic [31:0] ipc,
                               input logic [31:0] n, input logic err);
      exp_q.push_back({err, n, ipc, i});
   endtask

   // Monitor: compare every inst_valid pulse against the expected queue.
   task automatic monitor_loop();
      logic [SB_W-1:0] e;
      forever begin
         @(negedge clk);
         if (inst_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_inst_valid", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("sb_inst",      inst,              e[31:0]);
               check("sb_inst_pc",   inst_pc,           e[63:32]);
               check("sb_npc",       npc,               e[95:64]);
               check("sb_fetch_err", {31'd0, fetch_err}, {31'd0, e[96]});
            end
         end else if (fetch_err === 1'b1) begin
            check("fetch_err_without_valid", 32'd1, 32'd0);
         end
      end
   endtask

   initial begin
      int cnt;
      fork
         monitor_loop();
      join_none

      rst_n      = 1'b0;
      fetch_en   = 1'b0;
      pc         = '0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      tick();
      tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_inst",       inst,                  NOP);
      check("rst_npc",        npc,                   32'd4);
      check("rst_inst_pc",    inst_pc,               32'd0);
      check("rst_imem_req",   {31'd0, imem_req},     32'd0);
      check("rst_imem_addr",  imem_addr,             32'd0);
      check("rst_stall",      {31'd0, stall},        32'd0);
      check("rst_inst_valid", {31'd0, inst_valid},   32'd0);

      // Zero-wait fetch at 0x100
      tick();
      fetch_en = 1'b1; pc = 32'h100;
      expect_fetch(32'h0050_0093, 32'h100, 32'h104, 1'b0);
      tick();
      fetch_en = 1'b0;
      check("zw_req",   {31'd0, imem_req},    32'd1);
      check("zw_stall", {31'd0, stall},       32'd1);
      check("zw_addr",  imem_addr,            32'h100);
      check("zw_state", {31'd0, dbg_state_o}, 32'd1);
      imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
      tick();
      imem_ack = 1'b0;
      check("zw_latency_valid", {31'd0, inst_valid}, 32'd1);
      check("zw_req_dropped",   {31'd0, imem_req},   32'd0);
      check("zw_stall_low",     {31'd0, stall},      32'd0);
      tick();
      check("zw_valid_one_cycle", {31'd0, inst_valid}, 32'd0);
      check("zw_inst_held",       inst,                32'h0050_0093);

      // 3-wait-state fetch at 0x300; fetch_en/pc changes during REQ ignored
      fetch_en = 1'b1; pc = 32'h300;
      expect_fetch(32'hDEAD_BEEF, 32'h300, 32'h304, 1'b0);
      tick();
      pc = 32'h200;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (stall === 1'b1) cnt++;
         check("ws_addr_stable", imem_addr,         32'h300);
         check("ws_req_held",    {31'd0, imem_req}, 32'd1);
         tick();
      end
      if (stall === 1'b1) cnt++;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0; fetch_en = 1'b0;
      check("ws_stall_cycles", cnt, 32'd4);
      check("ws_valid",        {31'd0, inst_valid}, 32'd1);
      tick();
      check("ws_no_second_req", {31'd0, imem_req}, 32'd0);

      // Misaligned fetch at 0x102
      fetch_en = 1'b1; pc = 32'h102;
      expect_fetch(NOP, 32'h102, 32'h106, 1'b1);
      tick();
      fetch_en = 1'b0;
      check("mis_no_req",   {31'd0, imem_req},   32'd0);
      check("mis_no_stall", {31'd0, stall},      32'd0);
      check("mis_valid",    {31'd0, inst_valid}, 32'd1);
      tick();

      // ack while no request is outstanding
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0;
      check("stray_ack_ignored", {31'd0, inst_valid}, 32'd0);
      check("stray_ack_inst",    inst,                NOP);

      // Wrap at top of address space, then back-to-back fetch of 0
      fetch_en = 1'b1; pc = 32'hFFFF_FFFC;
      expect_fetch(32'h0000_0001, 32'hFFFF_FFFC, 32'h0, 1'b0);
      expect_fetch(32'h0000_0002, 32'h0,         32'h4, 1'b0);
      tick();
      pc = 32'h0;
      imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
      tick();
      imem_ack = 1'b0;
      check("b2b_first_valid", {31'd0, inst_valid}, 32'd1);
      check("b2b_idle_gap",    {31'd0, imem_req},   32'd0);
      tick();
      fetch_en = 1'b0;
      check("b2b_second_req",  {31'd0, imem_req},   32'd1);
      check("b2b_second_addr", imem_addr,           32'h0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0002;
      tick();
      imem_ack = 1'b0;
      check("b2b_second_valid", {31'd0, inst_valid}, 32'd1);
      tick();

      // Reset in the middle of a request; a late ack must be ignored
      fetch_en = 1'b1; pc = 32'h400;
      tick();
      fetch_en = 1'b0;
      check("mr_req_before", {31'd0, imem_req}, 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mr_req_dropped", {31'd0, imem_req}, 32'd0);
      check("mr_stall",       {31'd0, stall},    32'd0);
      check("mr_inst",        inst,              NOP);
      check("mr_npc",         npc,               32'd4);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_ack = 1'b0;
      check("mr_late_ack", {31'd0, inst_valid}, 32'd0);
      tick();

`ifdef IFETCH_TIMEOUT_EN
      // No ack: request aborts after 15 REQ cycles
      fetch_en = 1'b1; pc = 32'h500;
      expect_fetch(NOP, 32'h500, 32'h504, 1'b1);
      tick();
      fetch_en = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (imem_req !== 1'b1) break;
         cnt++;
         tick();
      end
      check("to_req_cycles", cnt,                  32'd15);
      check("to_valid",      {31'd0, inst_valid},  32'd1);
      tick();
`endif

      tick();
      check("sb_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end for the single-cycle/pipeline core.
- Consumes the program-counter address and runs a req/ack handshake with a variable-latency instruction memory.
- Latches the returned instruction and returns npc = fetched address + 4 to the PC stage.
- Raises stall while a fetch is outstanding; flags misaligned and timed-out fetches.

Parameters:
- ADDR_W, 32, address width (pc, npc, imem_addr, inst_pc).
- DATA_W, 32, instruction width.
- TIMEOUT, 15, max REQ cycles without ack before abort (legal range 1..255); used only with IFETCH_TIMEOUT_EN.
- NOP_INST, 32'h00000013, instruction substituted on error and driven at reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- fetch_en  in  1  core requests a fetch of pc; sampled only in IDLE.
- pc  in  ADDR_W  fetch address from the PC register.
- imem_req  out  1  memory request, held until ack.
- imem_addr  out  ADDR_W  request address, stable while imem_req=1.
- imem_ack  in  1  memory response strobe, valid only while imem_req=1.
- imem_rdata  in  DATA_W  instruction data, valid with imem_ack.
- inst  out  DATA_W  fetched instruction, held until next inst_valid.
- inst_pc  out  ADDR_W  address of inst.
- npc  out  ADDR_W  inst_pc + 4, modulo 2^ADDR_W.
- inst_valid  out  1  one-cycle pulse, new inst/inst_pc/npc.
- stall  out  1  high while in REQ.
- fetch_err  out  1  one-cycle pulse coincident with inst_valid on a failed fetch.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE, imem_req=0, imem_addr=0, inst=NOP_INST, inst_pc=0, npc=4, inst_valid=0, fetch_err=0, stall=0, wait counter=0.
  - Applies mid-REQ too: req drops at that edge; a later ack is ignored.
- FSM states: IDLE, REQ.
- IDLE, fetch_en=1, pc[1:0]==0:
  - imem_addr<=pc, imem_req<=1, counter<=0, go REQ.
- IDLE, fetch_en=1, pc[1:0]!=0 (misaligned):
  - no request issued; stay IDLE.
  - Next cycle: inst_valid=1, fetch_err=1, inst=NOP_INST, inst_pc=pc, npc=pc+4.
- IDLE, fetch_en=0: hold all outputs; pulses low.
- REQ:
  - stall=1; imem_req=1, imem_addr held; fetch_en and pc ignored.
  - On imem_ack=1 at edge: inst<=imem_rdata, inst_pc<=imem_addr, npc<=imem_addr+4, inst_valid<=1, imem_req<=0, go IDLE.
  - Without ack: counter increments.
- Latency:
  - fetch_en sampled at edge E0 -> imem_req high from E0.
  - Ack sampled at edge Ek -> inst_valid high in cycle after Ek.
  - Zero-wait memory (ack in first REQ cycle): inst_valid exactly 2 edges after fetch_en edge.
- Back-to-back: fetch_en high in the inst_valid cycle starts the next fetch at that edge (IDLE that cycle). Max throughput 1 instruction per 2 cycles.
- npc arithmetic: unsigned, wraps; inst_pc=32'hFFFFFFFC -> npc=0.
- imem_ack while imem_req=0: ignored.

Optional Feature:
- IFETCH_TIMEOUT_EN defined:
  - In REQ, when counter reaches TIMEOUT-1 with no ack on that edge: imem_req<=0, go IDLE.
  - Next cycle: inst_valid=1, fetch_err=1, inst=NOP_INST, inst_pc=imem_addr, npc=imem_addr+4.
  - Ack on the same edge as timeout wins (normal completion, no error).
- Undefined:
  - No counter logic; REQ waits indefinitely.
  - fetch_err only for misalignment.

Test Plan:
- Reset check: rst_n=0 one edge -> inst=0x00000013, npc=4, imem_req=0, stall=0, inst_valid=0.
- Zero-wait fetch: pc=0x100, fetch_en pulse, ack same cycle as req with rdata=0x00500093 -> inst_valid pulse 2 edges after fetch_en; inst=0x00500093, inst_pc=0x100, npc=0x104, fetch_err=0.
- 3-wait-state fetch: ack 3 cycles after req -> stall high 4 cycles; imem_addr stable; fetch_en toggled during REQ with pc=0x200 ignored.
- Misaligned fetch: pc=0x102 -> no imem_req; next cycle inst_valid=1, fetch_err=1, inst=NOP_INST, npc=0x106.
- Wrap and back-to-back: pc=0xFFFFFFFC fetched, then fetch_en held high with pc=0 -> npc=0x00000000; second req starts at first inst_valid edge.
- Timeout and mid-op reset (IFETCH_TIMEOUT_EN, TIMEOUT=15):
  - No ack -> req drops after 15 REQ cycles; fetch_err+inst_valid pulse.
  - Separately, rst_n=0 during REQ -> req low next edge; late ack produces no inst_valid.
